// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch front-end: address width default, NOP encoding and
// the record stored in the fetch queue.
package pipeline_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 9;
    localparam logic [31:0] NOP_INSTR      = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } fq_entry_t;

    localparam int unsigned ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: redirect input, instruction-memory port and ID-stage handshake.
// slave is the fetch_queue view; master is the surrounding pipeline/memory view.
interface fetch_queue_if
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_en;
    logic [31:0]       imem_data;
    logic              id_ready;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [31:0]       id_npc;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  redirect, redirect_pc, imem_data, id_ready,
        output imem_addr, imem_en, id_valid, id_instr, id_npc, count
    );

    modport master (
        output redirect, redirect_pc, imem_data, id_ready,
        input  imem_addr, imem_en, id_valid, id_instr, id_npc, count
    );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count. The caller must not
// push when full or pop when empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers returned instructions
// for the ID stage and squashes everything on a redirect.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    fq_entry_t         head;
    fq_entry_t         push_entry;
    logic              id_valid;
    logic              pop;
    logic              push;
    logic              fifo_pop;
    logic              fetch_en;
    logic [OCC_W-1:0]  occupancy;

    always_comb begin
        id_valid  = rst & (fifo_count != '0);
        pop       = id_valid & bus.id_ready;
        // Entries held plus the word still returning, minus what leaves this cycle.
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
        fetch_en  = rst & ~bus.redirect & (occupancy < OCC_W'(DEPTH));
        push      = rst & inflight_q & ~bus.redirect;
        fifo_pop  = pop & ~bus.redirect;

        push_entry.instr = bus.imem_data;
        push_entry.npc   = 32'(inflight_addr_q) + 32'd1;
    end

    always_comb begin
        pc_d            = pc_q;
        inflight_d      = fetch_en;
        inflight_addr_d = inflight_addr_q;
        if (bus.redirect) begin
            pc_d = bus.redirect_pc;
        end else if (fetch_en) begin
            pc_d            = pc_q + ADDR_W'(1);
            inflight_addr_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign head          = fq_entry_t'(fifo_rdata);
    assign bus.imem_addr = pc_q;
    assign bus.imem_en   = fetch_en;
    assign bus.id_valid  = id_valid;
    assign bus.id_instr  = id_valid ? head.instr : NOP_INSTR;
    assign bus.id_npc    = id_valid ? head.npc : 32'h0;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomised checks of fetch_queue against an instruction memory holding
// mem[a] = a + 100 with one cycle of read latency.
module tb_fetch_queue;
    import pipeline_pkg::*;

    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= 32'(bus.imem_addr) + 32'd100;
    end

    // Leaves rst low at a falling edge; the caller releases it to start cycle 0.
    task automatic do_reset();
        rst = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.id_instr); end
        checks++; if (bus.id_npc !== 32'h0) begin errors++; $display("FAIL reset_npc: got %h want 0", bus.id_npc); end
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b want 0", bus.imem_en); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_stream();
        do_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 9'd0) begin errors++; $display("FAIL stream_first_fetch: got en=%b addr=%0d want en=1 addr=0", bus.imem_en, bus.imem_addr); end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk); #1;
            if (k == 1) begin
                checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got valid=%b want 0 at cycle 1", bus.id_valid); end
            end else begin
                checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'(100 + k - 2)) begin errors++; $display("FAIL stream_instr c%0d: got v=%b %0d want 1 %0d", k, bus.id_valid, bus.id_instr, 100 + k - 2); end
                checks++; if (bus.id_npc !== 32'(k - 1)) begin errors++; $display("FAIL stream_npc c%0d: got %0d want %0d", k, bus.id_npc, k - 1); end
                checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL stream_count c%0d: got %0d want 1", k, bus.count); end
            end
            checks++; if (bus.imem_addr !== 9'(k)) begin errors++; $display("FAIL stream_addr c%0d: got %0d want %0d", k, bus.imem_addr, k); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rst = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk); #1;
            if (k >= 4) begin
                checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL bp_imem_en c%0d: got %b want 0", k, bus.imem_en); end
            end
            if (k >= 5) begin
                checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_count c%0d: got %0d want 4", k, bus.count); end
            end
        end
        @(negedge clk);
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 9'd4) begin errors++; $display("FAIL bp_resume: got en=%b addr=%0d want en=1 addr=4", bus.imem_en, bus.imem_addr); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (bus.id_instr !== 32'(100 + k) || bus.id_npc !== 32'(k + 1)) begin errors++; $display("FAIL bp_order %0d: got %0d/%0d want %0d/%0d", k, bus.id_instr, bus.id_npc, 100 + k, k + 1); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d want 3", bus.count); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h050;
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL redir_imem_en: got %b want 0", bus.imem_en); end
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count=%0d v=%b want 0 0", bus.count, bus.id_valid); end
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 9'h050) begin errors++; $display("FAIL redir_fetch: got en=%b addr=%h want 1 050", bus.imem_en, bus.imem_addr); end
        @(negedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_squash: got valid=%b instr=%0d want 0", bus.id_valid, bus.id_instr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'(180 + k) || bus.id_npc !== 32'(81 + k)) begin errors++; $display("FAIL redir_target %0d: got v=%b %0d/%0d want 1 %0d/%0d", k, bus.id_valid, bus.id_instr, bus.id_npc, 180 + k, 81 + k); end
        end
    endtask

    task automatic test_wrap();
        int exp_addr [4] = '{510, 511, 0, 1};
        int exp_instr [4] = '{610, 611, 100, 101};
        int exp_npc [4] = '{511, 512, 1, 2};
        do_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'd510;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            bus.redirect = 1'b0;
            #1;
            if (k <= 4) begin
                checks++; if (bus.imem_addr !== 9'(exp_addr[k-1])) begin errors++; $display("FAIL wrap_addr c%0d: got %0d want %0d", k, bus.imem_addr, exp_addr[k-1]); end
            end
            if (k >= 3) begin
                checks++; if (bus.id_instr !== 32'(exp_instr[k-3]) || bus.id_npc !== 32'(exp_npc[k-3])) begin errors++; $display("FAIL wrap_head c%0d: got %0d/%0d want %0d/%0d", k, bus.id_instr, bus.id_npc, exp_instr[k-3], exp_npc[k-3]); end
            end
        end
    endtask

    task automatic test_redirect_reset();
        do_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h050;
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL rr_imem_en: got %b want 0", bus.imem_en); end
        @(negedge clk);
        rst = 1'b1;
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rr_state: got count=%0d v=%b want 0 0", bus.count, bus.id_valid); end
        checks++; if (bus.imem_addr !== 9'd0 || bus.imem_en !== 1'b1) begin errors++; $display("FAIL rr_pc: got addr=%0d en=%b want 0 1", bus.imem_addr, bus.imem_en); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.id_instr !== 32'd100 || bus.id_npc !== 32'd1) begin errors++; $display("FAIL rr_first: got %0d/%0d want 100/1", bus.id_instr, bus.id_npc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.redirect = 1'b1;
        bus.redirect_pc = 9'h020;
        #1;
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL b2b_en1: got %b want 0", bus.imem_en); end
        @(negedge clk);
        bus.redirect_pc = 9'h030;
        #1;
        checks++; if (bus.imem_en !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL b2b_en2: got en=%b count=%0d want 0 0", bus.imem_en, bus.count); end
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 9'h030 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL b2b_pc: got addr=%h v=%b want 030 0", bus.imem_addr, bus.id_valid); end
        @(negedge clk); #1;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL b2b_squash: got valid=%b instr=%0d want 0", bus.id_valid, bus.id_instr); end
        @(negedge clk); #1;
        checks++; if (bus.id_instr !== 32'd148 || bus.id_npc !== 32'h31) begin errors++; $display("FAIL b2b_target: got %0d/%h want 148/31", bus.id_instr, bus.id_npc); end
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_addr = '0;
        int pops = 0;
        do_reset();
        rst = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            bus.id_ready = 1'($urandom_range(0, 1));
            bus.redirect = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = AW'($urandom_range(0, 511));
            #1;
            checks++; if (bus.count > 3'd4) begin errors++; $display("FAIL rand_count c%0d: got %0d want <=4", k, bus.count); end
            if (!bus.id_valid) begin
                checks++; if (bus.id_instr !== 32'h0 || bus.id_npc !== 32'h0) begin errors++; $display("FAIL rand_empty c%0d: got %0d/%0d want 0/0", k, bus.id_instr, bus.id_npc); end
            end
            if (bus.redirect) begin
                exp_addr = bus.redirect_pc;
            end else if (bus.id_valid && bus.id_ready) begin
                checks++; if (bus.id_instr !== 32'(exp_addr) + 32'd100 || bus.id_npc !== 32'(exp_addr) + 32'd1) begin errors++; $display("FAIL rand_pop c%0d: got %0d/%0d want %0d/%0d", k, bus.id_instr, bus.id_npc, 32'(exp_addr) + 100, 32'(exp_addr) + 1); end
                exp_addr = exp_addr + AW'(1);
                pops++;
            end
        end
        bus.redirect = 1'b0;
        checks++; if (pops < 50) begin errors++; $display("FAIL rand_progress: got %0d pops want >=50", pops); end
    endtask

    initial begin
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_redirect_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
